// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with memory-ready stalls and a retire counter.
// Define MULTICYCLE_CTRL_ADDI_EN to add the ADDI_EX/ADDI_WB path for opcode 8.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUop,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } state_t;

    state_t      cur, nxt;
    logic [5:0]  op_q;
    logic [15:0] count_q;
    logic        retire;

    // The opcode is captured in DECODE so MEMADR can tell lw from sw after IR moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= FETCH;
            op_q    <= 6'd0;
            count_q <= 16'd0;
        end else begin
            cur     <= nxt;
            if (cur == DECODE)
                op_q <= opcode;
            count_q <= count_q + {15'd0, retire};
        end
    end

    always_comb begin
        nxt         = FETCH;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        illegal_op  = 1'b0;

        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'd0:         nxt = EXEC;
                    6'd35, 6'd43: nxt = MEMADR;
                    6'd4:         nxt = BRANCH;
                    6'd2:         nxt = JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    6'd8:         nxt = ADDI_EX;
`endif
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (op_q == 6'd35) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
                retire   = mem_ready;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                nxt     = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
`endif
            default: nxt = FETCH;
        endcase

        // Reset must not let a half-finished instruction touch PC, IR, memory or registers.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign state       = cur;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: expected state, controls and count are queued per cycle.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegWrite, RegDst, ALUSrcA, illegal_op;
    logic [1:0]  PCSource, ALUSrcB, ALUop;
    logic [3:0]  state;
    logic [15:0] instr_count;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] model_cnt = 16'd0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUop(ALUop), .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic legalOp(input logic [5:0] op);
        logic ok;
        ok = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
`ifdef MULTICYCLE_CTRL_ADDI_EN
        ok = ok || (op == 6'd8);
`endif
        return ok;
    endfunction

    // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegWrite RegDst ALUSrcA PCSource ALUSrcB ALUop illegal_op
    function automatic logic [16:0] expCtrl(input logic [3:0] st, input logic mr,
                                            input logic [5:0] op, input logic rst);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa, ill;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa, ill} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1: begin asb = 2'b11; ill = !legalOp(op); end
            4'd2: begin asa = 1; asb = 2'b10; end
            4'd3: begin mrd = 1; iord = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin mwr = 1; iord = 1; end
            4'd6: begin asa = 1; aop = 2'b10; end
            4'd7: begin rw = 1; rd = 1; end
            4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9: begin pcw = 1; pcs = 2'b10; end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
`endif
            default: ;
        endcase
        if (rst) {pcw, pcwc, irw, mrd, mwr, rw, ill} = '0;
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa, pcs, asb, aop, ill};
    endfunction

    task automatic applyStimulus(input logic mr, input logic [5:0] op, input logic rst,
                                 input logic [3:0] st);
        exp_t e;
        mem_ready = mr;
        opcode    = op;
        reset     = rst;
        e.st   = st;
        e.ctrl = expCtrl(st, mr, op, rst);
        e.cnt  = model_cnt;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [16:0] got;
        #1;
        e   = sbq.pop_front();
        got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
               RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop, illegal_op};
        tests++;
        assert (state === e.st) else begin
            fails++;
            $error("FAIL state: observed %0d expected %0d", state, e.st);
        end
        tests++;
        assert (got === e.ctrl) else begin
            fails++;
            $error("FAIL ctrl (state %0d): observed %b expected %b", e.st, got, e.ctrl);
        end
        tests++;
        assert (instr_count === e.cnt) else begin
            fails++;
            $error("FAIL instr_count: observed %h expected %h", instr_count, e.cnt);
        end
    endtask

    task automatic cycle(input logic mr, input logic [5:0] op, input logic rst,
                         input logic [3:0] st);
        @(negedge clk);
        applyStimulus(mr, op, rst, st);
        checkOutput();
    endtask

    function automatic logic [5:0] rndOp();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rndBit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Opcode is only meaningful in DECODE; other cycles get garbage to prove it is latched.
    task automatic runInstr(input logic [5:0] op, input int fetchStall, input int memStall);
        for (int i = 0; i < fetchStall; i++) cycle(1'b0, rndOp(), 1'b0, 4'd0);
        cycle(1'b1, rndOp(), 1'b0, 4'd0);
        cycle(rndBit(), op, 1'b0, 4'd1);
        if (op == 6'd0) begin
            cycle(rndBit(), rndOp(), 1'b0, 4'd6);
            cycle(rndBit(), rndOp(), 1'b0, 4'd7);
            model_cnt++;
        end else if (op == 6'd35) begin
            cycle(rndBit(), rndOp(), 1'b0, 4'd2);
            for (int i = 0; i < memStall; i++) cycle(1'b0, rndOp(), 1'b0, 4'd3);
            cycle(1'b1, rndOp(), 1'b0, 4'd3);
            cycle(rndBit(), rndOp(), 1'b0, 4'd4);
            model_cnt++;
        end else if (op == 6'd43) begin
            cycle(rndBit(), rndOp(), 1'b0, 4'd2);
            for (int i = 0; i < memStall; i++) cycle(1'b0, rndOp(), 1'b0, 4'd5);
            cycle(1'b1, rndOp(), 1'b0, 4'd5);
            model_cnt++;
        end else if (op == 6'd4) begin
            cycle(rndBit(), rndOp(), 1'b0, 4'd8);
            model_cnt++;
        end else if (op == 6'd2) begin
            cycle(rndBit(), rndOp(), 1'b0, 4'd9);
            model_cnt++;
        end else if (legalOp(op)) begin
            cycle(rndBit(), rndOp(), 1'b0, 4'd10);
            cycle(rndBit(), rndOp(), 1'b0, 4'd11);
            model_cnt++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        cycle(1'b0, 6'd0, 1'b1, 4'd0);
        cycle(1'b1, 6'd0, 1'b1, 4'd0);

        runInstr(6'd0, 0, 0);
        runInstr(6'd35, 0, 3);
        runInstr(6'd4, 0, 0);
        runInstr(6'd2, 0, 0);
        runInstr(6'd63, 0, 0);
        runInstr(6'd8, 0, 0);
        runInstr(6'd43, 2, 1);
        runInstr(6'd35, 1, 0);

        cycle(1'b0, rndOp(), 1'b0, 4'd0);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        model_cnt = 16'hFFFF;
        runInstr(6'd2, 0, 0);

        cycle(1'b1, rndOp(), 1'b0, 4'd0);
        cycle(1'b1, 6'd43, 1'b0, 4'd1);
        cycle(1'b0, rndOp(), 1'b0, 4'd2);
        cycle(1'b0, rndOp(), 1'b0, 4'd5);
        cycle(1'b0, rndOp(), 1'b0, 4'd5);
        cycle(1'b0, rndOp(), 1'b1, 4'd5);
        model_cnt = 16'd0;
        cycle(1'b1, rndOp(), 1'b1, 4'd0);

        runInstr(6'd0, 1, 0);
        cycle(1'b0, rndOp(), 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
